// File: rtl/lpc_pkg.sv
// +----------------------------------------------------------------------------
// | Package : lpc_pkg
// | Shared defaults and burst sequencer state type for the LPC register bank.
// | Revision: 1.0
// +----------------------------------------------------------------------------
`default_nettype none

package lpc_pkg;
    localparam int LPC_WIDTH = 32;
    localparam int LPC_ORDER = 9;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } burst_state_t;
endpackage

`default_nettype wire

// File: rtl/lpc_onehot_dec.sv
// +----------------------------------------------------------------------------
// | Module  : lpc_onehot_dec
// | One-hot select to binary index, with an exactly-one-bit-set flag.
// | Revision: 1.0
// +----------------------------------------------------------------------------
`default_nettype none

module lpc_onehot_dec #(
    parameter int N  = 9,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  i_sel,
    output logic [IW-1:0] o_idx,
    output logic          o_onehot
);
    localparam logic [N-1:0] c_one = {{(N-1){1'b0}}, 1'b1};

    always_comb begin
        o_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (i_sel[i]) begin
                o_idx = o_idx | IW'(i);
            end
        end
    end

    // Non-zero and clearing the lowest set bit leaves nothing.
    assign o_onehot = (i_sel != '0) && ((i_sel & (i_sel - c_one)) == '0);
endmodule

`default_nettype wire

// File: rtl/lpc_regbank.sv
// +----------------------------------------------------------------------------
// | Module  : lpc_regbank
// | DEPTH x WIDTH coefficient/history bank: one-hot write, shift-in, registered
// | read and burst-read sequencer. Optional macro: LPC_REGBANK_SELCHK_EN.
// | Revision: 1.0
// +----------------------------------------------------------------------------
`default_nettype none

module lpc_regbank
    import lpc_pkg::*;
#(
    parameter int WIDTH = LPC_WIDTH,
    parameter int DEPTH = LPC_ORDER
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             wr_en,
    input  logic [DEPTH-1:0] wsel,
    input  logic             shift_en,
    input  logic [WIDTH-1:0] din,
    input  logic             rd_en,
    input  logic [DEPTH-1:0] rsel,
    input  logic             burst_start,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    output logic             burst_busy,
    output logic             burst_last,
    output logic             sel_err
);
    localparam int             IW     = $clog2(DEPTH);
    localparam logic [IW-1:0]  c_last = IW'(DEPTH - 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    burst_state_t     r_state;
    logic [IW-1:0]    r_idx;
    logic [WIDTH-1:0] r_dout;
    logic             r_valid;
    logic             r_busy;
    logic             r_last;

    logic [IW-1:0]    w_widx;
    logic [IW-1:0]    w_ridx;
    logic             w_w_onehot;
    logic             w_r_onehot;

    lpc_onehot_dec #(.N(DEPTH), .IW(IW)) u_wdec (
        .i_sel    (wsel),
        .o_idx    (w_widx),
        .o_onehot (w_w_onehot)
    );

    lpc_onehot_dec #(.N(DEPTH), .IW(IW)) u_rdec (
        .i_sel    (rsel),
        .o_idx    (w_ridx),
        .o_onehot (w_r_onehot)
    );

    // Shift has priority over a same-cycle write.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (shift_en) begin
            r_mem[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                r_mem[i] <= r_mem[i-1];
            end
        end else if (wr_en && w_w_onehot) begin
            r_mem[w_widx] <= din;
        end
    end

    // Word 0 is issued on the burst_start cycle so it appears one cycle later.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_dout  <= '0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_last  <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_busy <= 1'b0;
                    if (burst_start) begin
                        r_dout  <= r_mem[0];
                        r_valid <= 1'b1;
                        r_busy  <= 1'b1;
                        r_idx   <= IW'(1);
                        r_state <= BURST;
                    end else if (rd_en && w_r_onehot) begin
                        r_dout  <= r_mem[w_ridx];
                        r_valid <= 1'b1;
                    end
                end
                BURST: begin
                    r_dout  <= r_mem[r_idx];
                    r_valid <= 1'b1;
                    r_busy  <= 1'b1;
                    if (r_idx == c_last) begin
                        r_last  <= 1'b1;
                        r_idx   <= '0;
                        r_state <= IDLE;
                    end else begin
                        r_idx <= r_idx + IW'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign dout       = r_dout;
    assign dout_valid = r_valid;
    assign burst_busy = r_busy;
    assign burst_last = r_last;

`ifdef LPC_REGBANK_SELCHK_EN
    if (1) begin : g_selchk
        logic r_sel_err;
        logic w_bad_wr;
        logic w_bad_rd;

        assign w_bad_wr = wr_en && !shift_en && !w_w_onehot;
        assign w_bad_rd = rd_en && !w_r_onehot && (r_state == IDLE) && !burst_start;

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                r_sel_err <= 1'b0;
            end else if (w_bad_wr || w_bad_rd) begin
                r_sel_err <= 1'b1;
            end
        end

        assign sel_err = r_sel_err;
    end
`else
    assign sel_err = 1'b0;
`endif
endmodule

`default_nettype wire

// File: tb/tb_lpc_regbank.sv
// +----------------------------------------------------------------------------
// | Module  : tb_lpc_regbank
// | Directed vector table plus burst/reset sequences for lpc_regbank.
// | Revision: 1.0
// +----------------------------------------------------------------------------
`default_nettype none

module tb_lpc_regbank;
    localparam int W = 32;
    localparam int D = 9;
`ifdef LPC_REGBANK_SELCHK_EN
    localparam bit c_selchk = 1'b1;
`else
    localparam bit c_selchk = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset_n;
    logic         wr_en, shift_en, rd_en, burst_start;
    logic [D-1:0] wsel, rsel;
    logic [W-1:0] din;
    logic [W-1:0] dout;
    logic         dout_valid, burst_busy, burst_last, sel_err;

    int checks = 0;
    int errors = 0;
    bit exp_err = 1'b0;

    always #5 clk = ~clk;

    lpc_regbank dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .wr_en       (wr_en),
        .wsel        (wsel),
        .shift_en    (shift_en),
        .din         (din),
        .rd_en       (rd_en),
        .rsel        (rsel),
        .burst_start (burst_start),
        .dout        (dout),
        .dout_valid  (dout_valid),
        .burst_busy  (burst_busy),
        .burst_last  (burst_last),
        .sel_err     (sel_err)
    );

    typedef struct {
        logic         wr;
        logic [D-1:0] ws;
        logic         sh;
        logic [W-1:0] d;
        logic         rd;
        logic [D-1:0] rs;
        logic         bad;
        logic         ev;
        logic [W-1:0] edout;
    } vec_t;

    vec_t vecs [20];

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle_in();
        wr_en = 0; shift_en = 0; rd_en = 0; burst_start = 0;
        wsel = '0; rsel = '0; din = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [D-1:0] s, input logic [W-1:0] v);
        idle_in(); wr_en = 1; wsel = s; din = v;
        step();
        idle_in();
    endtask

    function automatic vec_t mk(input logic w, input logic [D-1:0] ws, input logic s,
                                input logic [W-1:0] d, input logic r, input logic [D-1:0] rs,
                                input logic bad, input logic ev, input logic [W-1:0] ed);
        vec_t v;
        v.wr = w; v.ws = ws; v.sh = s; v.d = d; v.rd = r; v.rs = rs;
        v.bad = bad; v.ev = ev; v.edout = ed;
        return v;
    endfunction

    logic [W-1:0] exp_burst [D];

    initial begin
        // wr ws sh din rd rs bad ev edout
        vecs[0]  = mk(1, 9'h004, 0, 32'h12345678, 0, 9'h000, 0, 0, 32'h0);
        vecs[1]  = mk(0, 9'h000, 0, 32'h0,        1, 9'h004, 0, 1, 32'h12345678);
        vecs[2]  = mk(0, 9'h000, 0, 32'h0,        0, 9'h000, 0, 0, 32'h12345678);
        vecs[3]  = mk(0, 9'h000, 1, 32'h1,        0, 9'h000, 0, 0, 32'h12345678);
        vecs[4]  = mk(0, 9'h000, 1, 32'h2,        0, 9'h000, 0, 0, 32'h12345678);
        vecs[5]  = mk(0, 9'h000, 1, 32'h3,        0, 9'h000, 0, 0, 32'h12345678);
        vecs[6]  = mk(0, 9'h000, 0, 32'h0,        1, 9'h001, 0, 1, 32'h3);
        vecs[7]  = mk(0, 9'h000, 0, 32'h0,        1, 9'h002, 0, 1, 32'h2);
        vecs[8]  = mk(0, 9'h000, 0, 32'h0,        1, 9'h004, 0, 1, 32'h1);
        vecs[9]  = mk(0, 9'h000, 0, 32'h0,        1, 9'h020, 0, 1, 32'h12345678);
        vecs[10] = mk(1, 9'h100, 1, 32'hAA,       0, 9'h000, 0, 0, 32'h12345678);
        vecs[11] = mk(0, 9'h000, 0, 32'h0,        1, 9'h100, 0, 1, 32'h0);
        vecs[12] = mk(0, 9'h000, 0, 32'h0,        1, 9'h001, 0, 1, 32'hAA);
        vecs[13] = mk(1, 9'h003, 0, 32'hFFFF,     0, 9'h000, 1, 0, 32'hAA);
        vecs[14] = mk(0, 9'h000, 0, 32'h0,        1, 9'h002, 0, 1, 32'h3);
        vecs[15] = mk(0, 9'h000, 0, 32'h0,        1, 9'h001, 0, 1, 32'hAA);
        vecs[16] = mk(0, 9'h000, 0, 32'h0,        1, 9'h000, 1, 0, 32'hAA);
        vecs[17] = mk(0, 9'h000, 0, 32'h0,        1, 9'h003, 1, 0, 32'hAA);
        vecs[18] = mk(1, 9'h002, 0, 32'h55,       1, 9'h002, 0, 1, 32'h3);
        vecs[19] = mk(0, 9'h000, 0, 32'h0,        1, 9'h002, 0, 1, 32'h55);

        idle_in();
        reset_n = 0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1;
        step();
        chk("reset_dout", dout, 32'h0);
        chk("reset_valid", W'(dout_valid), 32'h0);
        chk("reset_busy", W'(burst_busy), 32'h0);
        chk("reset_sel_err", W'(sel_err), 32'h0);

        // Async reset clears storage and outputs without a clock edge.
        wr(9'h008, 32'hDEADBEEF);
        rd_en = 1; rsel = 9'h008;
        step();
        idle_in();
        chk("pre_reset_read", dout, 32'hDEADBEEF);
        #2 reset_n = 0;
        #1;
        chk("async_reset_dout", dout, 32'h0);
        chk("async_reset_valid", W'(dout_valid), 32'h0);
        @(negedge clk);
        reset_n = 1;
        step();
        rd_en = 1; rsel = 9'h008;
        step();
        idle_in();
        chk("post_reset_e3_valid", W'(dout_valid), 32'h1);
        chk("post_reset_e3", dout, 32'h0);

        foreach (vecs[i]) begin
            wr_en = vecs[i].wr; wsel = vecs[i].ws; shift_en = vecs[i].sh;
            din = vecs[i].d; rd_en = vecs[i].rd; rsel = vecs[i].rs;
            step();
            idle_in();
            if (vecs[i].bad && c_selchk) exp_err = 1'b1;
            chk($sformatf("vec%0d_valid", i), W'(dout_valid), W'(vecs[i].ev));
            chk($sformatf("vec%0d_dout", i), dout, vecs[i].edout);
            chk($sformatf("vec%0d_sel_err", i), W'(sel_err), W'(exp_err));
            chk($sformatf("vec%0d_busy", i), W'({burst_busy, burst_last}), 32'h0);
        end

        // Burst with mid-burst write to a not-yet-read entry and ignored requests.
        for (int i = 0; i < D; i++) begin
            wr(D'(1) << i, 32'h10 + i);
            exp_burst[i] = 32'h10 + i;
        end
        exp_burst[6] = 32'h66;
        burst_start = 1;
        step();
        idle_in();
        for (int i = 0; i < D; i++) begin
            chk($sformatf("burst%0d_valid", i), W'(dout_valid), 32'h1);
            chk($sformatf("burst%0d_dout", i), dout, exp_burst[i]);
            chk($sformatf("burst%0d_last", i), W'(burst_last), W'(i == D - 1));
            chk($sformatf("burst%0d_busy", i), W'(burst_busy), 32'h1);
            idle_in();
            if (i == 3) begin
                wr_en = 1; wsel = 9'h040; din = 32'h66;
                rd_en = 1; rsel = 9'h001; burst_start = 1;
            end
            step();
        end
        chk("burst_end_valid", W'(dout_valid), 32'h0);
        chk("burst_end_busy", W'(burst_busy), 32'h0);
        chk("burst_end_last", W'(burst_last), 32'h0);
        chk("burst_end_hold", dout, 32'h18);
        chk("burst_sel_err", W'(sel_err), W'(exp_err));

        // Reset on the 4th valid word of a burst.
        burst_start = 1;
        step();
        idle_in();
        step(); step(); step();
        chk("rst_burst_4th_valid", W'(dout_valid), 32'h1);
        chk("rst_burst_4th_dout", dout, 32'h13);
        #1 reset_n = 0;
        #1;
        chk("rst_burst_valid", W'(dout_valid), 32'h0);
        chk("rst_burst_busy", W'(burst_busy), 32'h0);
        chk("rst_burst_sel_err", W'(sel_err), 32'h0);
        exp_err = 1'b0;
        @(negedge clk);
        reset_n = 1;
        step();
        step();
        chk("after_rst_no_valid", W'({dout_valid, burst_busy}), 32'h0);
        burst_start = 1;
        step();
        idle_in();
        for (int i = 0; i < D; i++) begin
            chk($sformatf("zburst%0d_valid", i), W'(dout_valid), 32'h1);
            chk($sformatf("zburst%0d_dout", i), dout, 32'h0);
            chk($sformatf("zburst%0d_last", i), W'(burst_last), W'(i == D - 1));
            step();
        end
        chk("zburst_end", W'({dout_valid, burst_busy, burst_last}), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

`default_nettype wire
